// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: takes a word and bit count over valid/ready, then shifts it
// out LSB-first with a qualifying valid, a done pulse on the last bit and an idle gap.
module seq_pattern_tx #(
    parameter int W     = 8,
    parameter int LEN_W = 4,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [LEN_W-1:0] in_len,
    input  logic             abort,
    output logic             o,
    output logic             o_valid,
    output logic             done,
    output logic             busy
);

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     shreg_q, shreg_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [GW-1:0]    gcnt_q, gcnt_d;
    logic             o_q, o_d;
    logic             o_valid_q, o_valid_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] eff_len;
    logic             accept;

    assign in_ready = (state_q == S_IDLE) & ~abort & ~rst;
    assign accept   = in_valid & in_ready;
    assign busy     = (state_q != S_IDLE);
    assign o        = o_q;
    assign o_valid  = o_valid_q;
    assign done     = done_q;

    // A zero or oversized length means "send the full word".
    assign eff_len = ((in_len == '0) || (32'(in_len) > W)) ? LEN_W'(W) : in_len;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        gcnt_d    = gcnt_q;
        o_d       = 1'b0;
        o_valid_d = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_SHIFT;
                    o_d       = in_data[0];
                    o_valid_d = 1'b1;
                    shreg_d   = in_data >> 1;
                    cnt_d     = eff_len - LEN_W'(1);
                    done_d    = (eff_len == LEN_W'(1));
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    gcnt_d  = '0;
                end else if (cnt_q != '0) begin
                    o_d       = shreg_q[0];
                    o_valid_d = 1'b1;
                    shreg_d   = shreg_q >> 1;
                    cnt_d     = cnt_q - LEN_W'(1);
                    done_d    = (cnt_q == LEN_W'(1));
                end else if (GAP > 0) begin
                    // cnt_q == 0: the last bit was on the line this cycle.
                    state_d = S_GAP;
                    gcnt_d  = GW'(GAP > 0 ? GAP - 1 : 0);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (abort || (gcnt_q == '0)) begin
                    state_d = S_IDLE;
                    gcnt_d  = '0;
                end else begin
                    gcnt_d = gcnt_q - GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            gcnt_q    <= '0;
            o_q       <= 1'b0;
            o_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            gcnt_q    <= gcnt_d;
            o_q       <= o_d;
            o_valid_q <= o_valid_d;
            done_q    <= done_d;
        end
    end

endmodule
